// File: rtl/tdc_thermo_encoder_if.sv
// TDC encoder bus: raw taps and enable in, fine-time bin results out.
// master drives the taps; slave is the encoder.
interface tdc_thermo_encoder_if #(
  parameter int NUM_TAPS = 240,
  parameter int BIN_W    = 8
);
  logic [NUM_TAPS-1:0] taps_in;
  logic                enable;
  logic [BIN_W-1:0]    bin_out;
  logic                bin_valid;
  logic                overflow;
  logic [15:0]         hit_count;

  modport master (
    output taps_in, enable,
    input  bin_out, bin_valid, overflow, hit_count
  );

  modport slave (
    input  taps_in, enable,
    output bin_out, bin_valid, overflow, hit_count
  );
endinterface

// File: rtl/tdc_thermo_encoder.sv
// TDC thermometer encoder: 2-flop capture, bubble correction,
// pipelined ones-count, dead time and code-density hit counter.
module tdc_thermo_encoder #(
  parameter int NUM_TAPS    = 240,
  parameter int BIN_W       = 8,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tdc_thermo_encoder_if.slave   bus
);
  localparam int NG = (NUM_TAPS + 15) / 16;
  localparam int PW = NG * 16;
  localparam int DW = $clog2(DEAD_CYCLES + 1);

  logic [NUM_TAPS-1:0] q1_q, q2_q;
  logic [NUM_TAPS-1:0] c_q, c_d;
  logic                c0_prev_q;
  logic [1:0]          arm_cnt_q;
  logic                armed_q;
  logic [DW-1:0]       dead_q, dead_d;
  logic                ev_d;
  logic [NG-1:0][4:0]  grp_q, grp_d;
  logic                ev4_q;
  logic                valid_q;
  logic [BIN_W-1:0]    bin_q, sum_d;
  logic                ovf_q;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [NUM_TAPS+1:0] ext;
  logic [PW-1:0]       pad;

  // ext[i] is q2[i-1]; virtual taps: q2[-1]=1, q2[NUM_TAPS]=0
  always_comb begin
    ext = {1'b0, q2_q, 1'b1};
    c_d = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      c_d[i] = (ext[i] & ext[i+1]) |
               (ext[i] & ext[i+2]) |
               (ext[i+1] & ext[i+2]);
    end
  end

  always_comb begin
    ev_d = c_q[0] & ~c0_prev_q & bus.enable &
           armed_q & (dead_q == '0);
    dead_d = dead_q;
    if (ev_d)
      dead_d = DW'(DEAD_CYCLES);
    else if (dead_q != '0)
      dead_d = dead_q - 1'b1;
  end

  always_comb begin
    pad = '0;
    pad[NUM_TAPS-1:0] = c_q;
    grp_d = '0;
    for (int g = 0; g < NG; g++) begin
      for (int k = 0; k < 16; k++) begin
        grp_d[g] = grp_d[g] + 5'(pad[g*16+k]);
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int g = 0; g < NG; g++) begin
      sum_d = sum_d + BIN_W'(grp_q[g]);
    end
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (ev4_q && hit_cnt_q != 16'hFFFF)
      hit_cnt_d = hit_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q1_q      <= '0;
      q2_q      <= '0;
      c_q       <= '0;
      c0_prev_q <= 1'b0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      dead_q    <= '0;
      grp_q     <= '0;
      ev4_q     <= 1'b0;
      valid_q   <= 1'b0;
      bin_q     <= '0;
      ovf_q     <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      q1_q      <= bus.taps_in;
      q2_q      <= q1_q;
      c_q       <= c_d;
      c0_prev_q <= c_q[0];
      // armed once c0_prev holds a sample taken after reset
      if (arm_cnt_q != 2'd3)
        arm_cnt_q <= arm_cnt_q + 2'd1;
      else
        armed_q <= 1'b1;
      dead_q    <= dead_d;
      grp_q     <= grp_d;
      ev4_q     <= ev_d;
      valid_q   <= ev4_q;
      if (ev4_q)
        bin_q   <= sum_d;
      ovf_q     <= ev4_q && (sum_d == BIN_W'(NUM_TAPS));
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.hit_count = hit_cnt_q;
endmodule

// File: doc/tdc_thermo_encoder.md
# tdc_thermo_encoder

Downstream stage of the TDC tapped delay line: samples the raw thermometer code produced when a hit (real or debug-generated) propagates through the carry-chain taps. It bubble-corrects the code and converts it to a fine-time bin through a pipelined ones-count. It emits one bin per hit with a valid pulse, an overflow flag and a hit counter for code-density calibration sweeps.

## Interface
- `NUM_TAPS`, 240, number of delay-line taps; tap 0 is the first tap reached by the hit.
- `BIN_W`, 8, bin width; must satisfy 2^BIN_W > NUM_TAPS.
- `DEAD_CYCLES`, 4, clock cycles after an accepted hit during which new hits are ignored; must be at least 1.
- `clk  input  1  system clock; all logic on rising edge.`
- `rst  input  1  synchronous, active-low reset.`
- `taps_in  input  NUM_TAPS  raw tap outputs, asynchronous to clk.`
- `enable  input  1  hit acceptance enable.`
- `bin_out  output  BIN_W  fine-time bin (corrected ones-count); held between valids.`
- `bin_valid  output  1  one-cycle pulse per accepted hit.`
- `overflow  output  1  qualifies bin_valid; 1 when all taps are set (bin_out == NUM_TAPS).`
- `hit_count  output  16  number of bin_valid pulses since reset; saturates at 0xFFFF.`

## Operation
- Reset (rst==0 at an edge): every register clears to 0, including the sync stages, the corrected word, partial sums, the dead-time counter and the armed flag. Outputs read `bin_out=0`, `bin_valid=0`, `overflow=0`, `hit_count=0`.
- Stage S1/S2: two-flop capture of `taps_in` (`q1`, then `q2`), with no logic between them.
- Stage S3, bubble correction: `c[i] = majority(q2[i-1], q2[i], q2[i+1])`, with virtual `q2[-1]=1` and `q2[NUM_TAPS]=0`. `c` is registered, and `c0_prev` holds the previous `c[0]`.
- Hit event:
  - Definition: `c[0]==1`, `c0_prev==0`, `enable==1`, armed, and the dead-time counter is 0.
  - Armed rule: armed sets once `c` and `c0_prev` both hold post-reset samples. Taps held high across reset release must not produce an event. A new event requires `taps_in[0]` to go low and then high.
  - Dead time: an accepted event loads the dead-time counter with DEAD_CYCLES. The counter decrements to 0 each cycle and saturates at 0. Rising edges of `c[0]` seen while the counter is nonzero are dropped and not queued.
  - Enable: `enable==0` suppresses events only. The pipeline keeps running and the dead-time counter keeps decrementing.
- Stage S4: `c` is split into 16-tap groups; the last group is zero-padded when NUM_TAPS is not a multiple of 16. Each group's 5-bit popcount is registered, and the event flag is registered alongside.
- Stage S5: the group sums are added into the BIN_W-bit `bin_out`.
  - `bin_valid` equals the delayed event flag.
  - `overflow` is set to (sum == NUM_TAPS) on valid cycles and cleared otherwise.
  - `bin_out` loads only on valid cycles.
- `hit_count` increments on each `bin_valid` pulse and stops at 0xFFFF; only reset clears it.
- A non-thermometer pattern surviving correction is still counted as ones. It is not flagged.

## Timing
- Latency: if `taps_in` changes before edge E1, `bin_valid` and `bin_out` are high and valid after edge E5, i.e. 5 clk edges.
- Throughput: at most one `bin_valid` per DEAD_CYCLES+1 cycles.
- `bin_valid` is exactly one cycle wide. Back-to-back pulses are impossible.
- Reset mid-operation: in-flight events are discarded. No `bin_valid` appears for reset-era samples.
- `hit_count` updates on the same edge that raises `bin_valid`, so the new value is visible together with the pulse.
- `enable` is sampled at S3, aligned with the `c` register. A hit whose S3 cycle sees `enable==0` is lost even if `enable` rises later.

## Test plan
- Reset: hold `rst=0` for 3 cycles with `taps_in` all ones, release, and keep the taps high for 20 cycles. Required: `bin_valid` never asserts, and `bin_out=0`, `overflow=0`, `hit_count=0`.
- Clean hit: set `taps_in=0` for 10 cycles, then set taps[39:0]=1. Required: a single `bin_valid` pulse after exactly 5 edges, `bin_out=40`, `overflow=0`, `hit_count=1`.
- Bubbles: set taps[39:0]=1 with bit 20 cleared and bit 45 set, preceded by all-zero. Required: `bin_out=40`, `overflow=0`.
- Overflow: go from all-zero to all 240 taps set. Required: `bin_out=240`, `overflow=1` on the valid cycle and 0 on the following cycle.
- Dead time (DEAD_CYCLES=4): apply `taps_in[0]` rising edges 2 cycles apart. Required: one `bin_valid`. Rising edges 6 cycles apart require two `bin_valid` pulses, and `hit_count` advances by 1 and by 2 respectively.
- Enable and saturation: five hits with `enable=0` leave `hit_count` unchanged and produce no `bin_valid`. Forcing `hit_count` to 0xFFFE and then applying 3 hits gives a final value of 0xFFFF.
